dmac_reg_bank: RTL and testbench

DMAC register bank and channel-0 control. It sits directly behind the DMAC AHB slave interface and holds the address-phase register offset. It captures write data when the slave flags a valid register write and presents every programmable register back to the slave for read-data muxing. It also drives start/abort pulses to the channel-0 transfer engine and collects its completion into a maskable interrupt.

---
 rtl/dmac_reg_bank.sv | 125 ++++++++++++
 tb/tb_dmac_reg_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_reg_bank.sv
// DMAC register bank with channel-0 start/abort control and terminal-count IRQ.
// Ports: AHB offset/data/qualifiers in, dma_done in; registers, IRQ, start/abort out.
module dmac_reg_bank (
  input  logic        s_HCLK,
  input  logic        s_HRESETn,
  input  logic [31:0] s_HADDR,
  input  logic [31:0] s_HWDATA,
  input  logic        load_ahb_addr,
  input  logic        write_out_reg,
  input  logic        dma_done,
  output logic [11:0] DMAC_HADDR_REG,
  output logic        DMAC_Configuration,
  output logic [31:0] DMAC_C0_SrcAddr,
  output logic [31:0] DMAC_C0_DestAddr,
  output logic [14:0] DMAC_C0_Control,
  output logic        DMAC_C0_Configuration,
  output logic        DMACINTR_mask,
  output logic        DMACINTR_pend,
  output logic        DMACINTR,
  output logic        dma_start,
  output logic        dma_abort
);

  localparam logic [11:0] ADDR_CFG  = 12'h030;
  localparam logic [11:0] ADDR_SRC  = 12'h100;
  localparam logic [11:0] ADDR_DST  = 12'h104;
  localparam logic [11:0] ADDR_CTL  = 12'h10C;
  localparam logic [11:0] ADDR_CH   = 12'h110;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [11:0] r_haddr;
  logic        r_cfg;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [14:0] r_ctl;
  logic [0:0]  r_state;
  logic        r_mask;
  logic        r_pend;
  logic        r_intr;
  logic        r_start;
  logic        r_abort;

  logic w_active;
  logic w_wr_cfg;
  logic w_wr_src;
  logic w_wr_dst;
  logic w_wr_ctl;
  logic w_wr_ch;
  logic w_done;
  logic w_start;
  logic w_abort;
  logic w_cfg_ok;

  // Decode uses the offset latched before this edge, so a
  // back-to-back address phase cannot steer the current write.
  assign w_active = (r_state == ST_ACTIVE);
  assign w_wr_cfg = write_out_reg && (r_haddr == ADDR_CFG);
  assign w_wr_src = write_out_reg && (r_haddr == ADDR_SRC);
  assign w_wr_dst = write_out_reg && (r_haddr == ADDR_DST);
  assign w_wr_ctl = write_out_reg && (r_haddr == ADDR_CTL);
  assign w_wr_ch  = write_out_reg && (r_haddr == ADDR_CH);

  assign w_done  = dma_done && w_active;
  assign w_start = w_wr_ch && s_HWDATA[0] && !w_active && r_cfg;
  // Completion in the same cycle as a disable suppresses abort.
  assign w_abort = w_wr_ch && !s_HWDATA[0] && w_active && !dma_done;
  // Global disable is refused while the channel still runs.
  assign w_cfg_ok = s_HWDATA[0] || !w_active;

  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      r_haddr <= '0;
      r_cfg   <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_ctl   <= '0;
      r_state <= ST_IDLE;
      r_mask  <= 1'b0;
      r_pend  <= 1'b0;
      r_intr  <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (load_ahb_addr)
        r_haddr <= s_HADDR[11:0];
      if (w_wr_cfg && w_cfg_ok)
        r_cfg <= s_HWDATA[0];
      if (w_wr_src && !w_active)
        r_src <= s_HWDATA;
      if (w_wr_dst && !w_active)
        r_dst <= s_HWDATA;
      if (w_wr_ctl && !w_active)
        r_ctl <= s_HWDATA[14:0];
      if (w_done || w_abort)
        r_state <= ST_IDLE;
      else if (w_start)
        r_state <= ST_ACTIVE;
      if (w_wr_ch)
        r_mask <= s_HWDATA[1];
      // Set beats write-1-to-clear.
      if (w_done)
        r_pend <= 1'b1;
      else if (w_wr_ch && s_HWDATA[2])
        r_pend <= 1'b0;
      r_intr  <= r_pend && r_mask;
      r_start <= w_start;
      r_abort <= w_abort;
    end
  end

  assign DMAC_HADDR_REG        = r_haddr;
  assign DMAC_Configuration    = r_cfg;
  assign DMAC_C0_SrcAddr       = r_src;
  assign DMAC_C0_DestAddr      = r_dst;
  assign DMAC_C0_Control       = r_ctl;
  assign DMAC_C0_Configuration = r_state;
  assign DMACINTR_mask         = r_mask;
  assign DMACINTR_pend         = r_pend;
  assign DMACINTR              = r_intr;
  assign dma_start             = r_start;
  assign dma_abort             = r_abort;

endmodule

// File: tb/tb_dmac_reg_bank.sv
// Scoreboard bench for dmac_reg_bank.
// Expectations are queued with a target cycle and checked at negedge.
module tb_dmac_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        ld;
  logic        wr;
  logic        done;
  logic [11:0] o_haddr;
  logic        o_cfg;
  logic [31:0] o_src;
  logic [31:0] o_dst;
  logic [14:0] o_ctl;
  logic        o_ccfg;
  logic        o_mask;
  logic        o_pend;
  logic        o_intr;
  logic        o_start;
  logic        o_abort;

  int checks;
  int failures;
  int n;

  typedef struct {
    int          cyc;
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];

  dmac_reg_bank dut (
    .s_HCLK               (clk),
    .s_HRESETn            (rst_n),
    .s_HADDR              (haddr),
    .s_HWDATA             (hwdata),
    .load_ahb_addr        (ld),
    .write_out_reg        (wr),
    .dma_done             (done),
    .DMAC_HADDR_REG       (o_haddr),
    .DMAC_Configuration   (o_cfg),
    .DMAC_C0_SrcAddr      (o_src),
    .DMAC_C0_DestAddr     (o_dst),
    .DMAC_C0_Control      (o_ctl),
    .DMAC_C0_Configuration(o_ccfg),
    .DMACINTR_mask        (o_mask),
    .DMACINTR_pend        (o_pend),
    .DMACINTR             (o_intr),
    .dma_start            (o_start),
    .dma_abort            (o_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) n <= n + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0:  return {20'b0, o_haddr};
      1:  return {31'b0, o_cfg};
      2:  return o_src;
      3:  return o_dst;
      4:  return {17'b0, o_ctl};
      5:  return {31'b0, o_ccfg};
      6:  return {31'b0, o_mask};
      7:  return {31'b0, o_pend};
      8:  return {31'b0, o_intr};
      9:  return {31'b0, o_start};
      10: return {31'b0, o_abort};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  localparam int HADDR = 0;
  localparam int CFG   = 1;
  localparam int SRC   = 2;
  localparam int DST   = 3;
  localparam int CTL   = 4;
  localparam int CCFG  = 5;
  localparam int MASK  = 6;
  localparam int PEND  = 7;
  localparam int INTR  = 8;
  localparam int START = 9;
  localparam int ABORT = 10;

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= n) begin
        chk(q[i].tag, obs(q[i].sel), q[i].val);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic ex(int d, string tag, int sel, logic [31:0] v);
    exp_t e;
    e.cyc = n + d;
    e.sel = sel;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drv(logic l, logic [11:0] a, logic w,
                     logic [31:0] d, logic dn);
    @(posedge clk);
    #1;
    ld     = l;
    haddr  = {$urandom_range(0, 32'hFFFFF), a};
    wr     = w;
    hwdata = w ? d : $urandom;
    done   = dn;
  endtask

  task automatic idle();
    drv(1'b0, 12'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wreg(logic [11:0] a, logic [31:0] d);
    drv(1'b1, a, 1'b0, 32'h0, 1'b0);
    drv(1'b0, 12'h0, 1'b1, d, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ld     = 1'b0;
    wr     = 1'b0;
    done   = 1'b0;
    haddr  = '0;
    hwdata = '0;
    #13;
    for (int s = 0; s <= 10; s++)
      chk($sformatf("rst_out%0d", s), obs(s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    idle();
    ex(1, "rel_cfg", CFG, 0);
    ex(1, "rel_ccfg", CCFG, 0);
    ex(1, "rel_haddr", HADDR, 0);

    wreg(12'h030, 32'h1);
    ex(1, "gcfg_on", CFG, 1);
    ex(1, "haddr_030", HADDR, 32'h030);
    wreg(12'h100, 32'h1000_0000);
    ex(1, "src_wr", SRC, 32'h1000_0000);

    drv(1'b1, 12'h104, 1'b0, 32'h0, 1'b0);
    drv(1'b1, 12'h10C, 1'b1, 32'hAAAA_5555, 1'b0);
    ex(1, "b2b_dst", DST, 32'hAAAA_5555);
    ex(1, "b2b_ctl_hold", CTL, 0);
    ex(1, "b2b_haddr", HADDR, 32'h10C);
    drv(1'b0, 12'h0, 1'b1, 32'h0000_7FFF, 1'b0);
    ex(1, "b2b_ctl", CTL, 32'h7FFF);
    ex(1, "b2b_dst_keep", DST, 32'hAAAA_5555);

    wreg(12'h110, 32'h3);
    ex(1, "en_ccfg", CCFG, 1);
    ex(1, "en_start", START, 1);
    ex(1, "en_mask", MASK, 1);
    ex(1, "en_abort", ABORT, 0);
    idle();
    ex(1, "start_1cyc", START, 0);
    wreg(12'h100, 32'hFFFF_FFFF);
    ex(1, "src_locked", SRC, 32'h1000_0000);

    drv(1'b0, 12'h0, 1'b0, 32'h0, 1'b1);
    ex(1, "done_ccfg", CCFG, 0);
    ex(1, "done_pend", PEND, 1);
    ex(1, "done_intr_lag", INTR, 0);
    idle();
    ex(1, "done_intr", INTR, 1);
    wreg(12'h110, 32'h4);
    ex(1, "w1c_pend", PEND, 0);
    ex(1, "w1c_mask", MASK, 0);
    ex(1, "w1c_intr_lag", INTR, 1);
    ex(1, "w1c_abort", ABORT, 0);
    idle();
    ex(1, "w1c_intr", INTR, 0);

    wreg(12'h110, 32'h3);
    ex(1, "en2_start", START, 1);
    idle();
    drv(1'b1, 12'h110, 1'b0, 32'h0, 1'b0);
    drv(1'b0, 12'h0, 1'b1, 32'h2, 1'b1);
    ex(1, "dd_pend", PEND, 1);
    ex(1, "dd_ccfg", CCFG, 0);
    ex(1, "dd_abort", ABORT, 0);
    ex(1, "dd_mask", MASK, 1);
    idle();
    ex(1, "dd_abort2", ABORT, 0);
    ex(1, "dd_intr", INTR, 1);

    wreg(12'h110, 32'h3);
    ex(1, "en3_ccfg", CCFG, 1);
    idle();
    drv(1'b1, 12'h110, 1'b0, 32'h0, 1'b0);
    drv(1'b0, 12'h0, 1'b1, 32'h7, 1'b1);
    ex(1, "setwin_pend", PEND, 1);
    ex(1, "setwin_ccfg", CCFG, 0);
    ex(1, "setwin_abort", ABORT, 0);
    ex(1, "setwin_start", START, 0);
    wreg(12'h110, 32'h6);
    ex(1, "clr_pend", PEND, 0);
    ex(1, "clr_mask", MASK, 1);

    wreg(12'h110, 32'h3);
    ex(1, "en4_ccfg", CCFG, 1);
    idle();
    wreg(12'h030, 32'h0);
    ex(1, "gcfg_locked", CFG, 1);
    wreg(12'h110, 32'h2);
    ex(1, "dis_ccfg", CCFG, 0);
    ex(1, "dis_abort", ABORT, 1);
    ex(1, "dis_start", START, 0);
    idle();
    ex(1, "abort_1cyc", ABORT, 0);

    wreg(12'h030, 32'h0);
    ex(1, "gcfg_off", CFG, 0);
    wreg(12'h110, 32'h1);
    ex(1, "noen_ccfg", CCFG, 0);
    ex(1, "noen_start", START, 0);
    idle();
    ex(1, "noen_start2", START, 0);
    drv(1'b0, 12'h0, 1'b0, 32'h0, 1'b1);
    ex(1, "idle_done_pend", PEND, 0);
    ex(1, "idle_done_ccfg", CCFG, 0);

    wreg(12'h200, 32'hFFFF_FFFF);
    ex(1, "bad_cfg", CFG, 0);
    ex(1, "bad_src", SRC, 32'h1000_0000);
    ex(1, "bad_dst", DST, 32'hAAAA_5555);
    ex(1, "bad_ctl", CTL, 32'h7FFF);
    ex(1, "bad_mask", MASK, 0);
    ex(1, "bad_pend", PEND, 0);
    ex(1, "bad_ccfg", CCFG, 0);
    ex(1, "bad_haddr", HADDR, 32'h200);

    idle();
    idle();
    idle();
    @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
